// File: rtl/sdp_ram_reader.sv
// Read-side engine for the registered-read simple dual-port RAM: streams a window out.
// Optional m_last output enabled by defining SDP_RAM_READER_LAST_EN.
module sdp_ram_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef SDP_RAM_READER_LAST_EN
  ,
  output logic                  m_last
`endif
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_tag_a;
  logic                  r_tag_b;
  logic [LW-1:0]         r_rem_issue;
  logic [LW-1:0]         r_rem_out;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [CW-1:0]         r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_start_go;
  logic          w_last_beat;
  logic [CW-1:0] w_occ;

  assign w_push      = r_tag_b;
  assign w_pop       = m_valid && m_ready;
  assign w_occ       = r_count + CW'(r_tag_a) + CW'(r_tag_b) - CW'(w_pop);
  assign w_start_go  = (r_state == S_IDLE) && start && (length != '0);
  assign w_issue     = w_start_go ||
                       ((r_state == S_RUN) && (r_rem_issue != '0) &&
                        (w_occ < CW'(FIFO_DEPTH)));
  assign w_last_beat = w_pop && (r_rem_out == LW'(1));

  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign ram_read_addr = r_addr;
  assign m_valid       = (r_count != '0);
  assign m_data        = m_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = (length == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_last_beat) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stage A is the address register, stage B aligns with the RAM q output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_tag_a     <= 1'b0;
      r_tag_b     <= 1'b0;
      r_rem_issue <= '0;
      r_rem_out   <= '0;
    end else begin
      r_tag_a <= w_issue;
      r_tag_b <= r_tag_a;
      if (w_start_go) begin
        r_addr      <= base_addr;
        r_rem_issue <= length - LW'(1);
        r_rem_out   <= length;
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + ADDR_WIDTH'(1);
          r_rem_issue <= r_rem_issue - LW'(1);
        end
        if (w_pop) r_rem_out <= r_rem_out - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= ram_q;
  end

`ifdef SDP_RAM_READER_LAST_EN
  logic r_last_a;
  logic r_last_b;
  logic r_mem_last [FIFO_DEPTH];
  logic w_issue_last;

  assign w_issue_last = w_issue &&
                        (w_start_go ? (length == LW'(1))
                                    : (r_rem_issue == LW'(1)));
  assign m_last = m_valid && r_mem_last[r_rd];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_a <= 1'b0;
      r_last_b <= 1'b0;
    end else begin
      r_last_a <= w_issue_last;
      r_last_b <= r_last_a;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem_last[r_wr] <= r_last_b;
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sdp_ram_reader.sv
// Scoreboard bench for sdp_ram_reader: directed commands against a RAM[i]=i model.
// Define SDP_RAM_READER_LAST_EN to also check m_last.
module tb_sdp_ram_reader;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] length = '0;
  logic       busy;
  logic       done;
  logic [5:0] ram_read_addr;
  logic [7:0] ram_q;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
`ifdef SDP_RAM_READER_LAST_EN
  logic       m_last;
`endif

  sdp_ram_reader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .ram_read_addr(ram_read_addr),
    .ram_q(ram_q),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready)
`ifdef SDP_RAM_READER_LAST_EN
    ,
    .m_last(m_last)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] ram [64];
  always @(posedge clk) ram_q <= ram[ram_read_addr];

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cmd_t0 = 0;
  int cmd_beats = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_base = 0;
  int seen_valid = 0;
  int addr_c1 = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 0;
    end else begin
      if (cyc == cmd_t0 + 1) addr_c1 = int'(ram_read_addr);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_valid) seen_valid++;
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_data", int'(m_data), int'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got data %0d expected no beat", m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", int'(m_data), int'(e.d));
`ifdef SDP_RAM_READER_LAST_EN
          chk("last", int'(m_last), int'(e.l));
`endif
        end
        if (cmd_beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        cmd_beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic launch(input int b, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{ram[(b + i) % 64], (i == len - 1)});
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 6'(b);
    length    = 7'(len);
    cmd_t0    = cyc;
    cmd_beats = 0;
    busy_cnt  = 0;
    done_base = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input bit tog);
    int ph;
    ph = 0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      if (tog) begin
        m_ready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end
      @(negedge clk);
      #1;
      if (done_cnt != done_base) break;
    end
    m_ready = 1'b1;
    chk(nm, done_cnt - done_base, 1);
  endtask

  initial begin
    int sv;
    int a0;
    for (int i = 0; i < 64; i++) ram[i] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_addr", int'(ram_read_addr), 0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Basic window with exact latency
    launch(5, 4);
    wait_done("t1_done", 0);
    chk("t1_addr_c1", addr_c1, 5);
    chk("t1_first", first_cyc - cmd_t0, 3);
    chk("t1_lastbeat", last_cyc - cmd_t0, 6);
    chk("t1_donecyc", done_cyc - cmd_t0, 7);
    chk("t1_busy", busy_cnt, 6);
    chk("t1_beats", cmd_beats, 4);

    // Address wrap
    launch(62, 4);
    wait_done("t2_done", 0);
    chk("t2_addr_c1", addr_c1, 62);
    chk("t2_beats", cmd_beats, 4);
    chk("t2_first", first_cyc - cmd_t0, 3);

    // Full depth with backpressure
    launch(0, 64);
    wait_done("t3_done", 1);
    chk("t3_beats", cmd_beats, 64);
    chk("t3_empty", exp_q.size(), 0);

    // Zero length
    sv = seen_valid;
    a0 = int'(ram_read_addr);
    launch(17, 0);
    wait_done("t4_done", 0);
    chk("t4_donecyc", done_cyc - cmd_t0, 1);
    chk("t4_busy", busy_cnt, 0);
    chk("t4_novalid", seen_valid - sv, 0);
    chk("t4_addr", int'(ram_read_addr), a0);

    // Start during RUN is ignored
    launch(20, 6);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 6'd40;
    length    = 7'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5_done", 0);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_onedone", done_cnt - done_base, 1);
    chk("t5_beats", cmd_beats, 6);
    chk("t5_empty", exp_q.size(), 0);

    // Reset abort after 3 beats
    launch(30, 8);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (cmd_beats >= 3) break;
    end
    chk("t6_three", cmd_beats, 3);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid", int'(m_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_addr", int'(ram_read_addr), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_nodone", done_cnt - done_base, 0);
    chk("t6_novalid", int'(m_valid), 0);
    launch(0, 2);
    wait_done("t6b_done", 0);
    chk("t6b_beats", cmd_beats, 2);
    chk("t6b_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdp_ram_reader.md
Name: sdp_ram_reader

Overview:
- Read-side engine for the team's simple dual-port RAM (registered read, 1-cycle read latency).
- On a start command, walks a contiguous address window and drives the RAM read_addr port.
- Absorbs the registered-read latency and streams the words out on a valid/ready interface with backpressure.
- The data counterpart to the RAM's write-side producers: DMA-style readout of line and frame buffers.

Parameters:
DATA_WIDTH, 8, width of RAM word and stream data
ADDR_WIDTH, 6, RAM address width; RAM depth is 2**ADDR_WIDTH
FIFO_DEPTH, 4, output buffer entries; must be power of two and at least 4

Ports:
clk  input  1  single clock; also clocks the attached RAM
resetn  input  1  asynchronous, active-low reset
start  input  1  1-cycle command; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first word address, sampled with start
length  input  ADDR_WIDTH+1  words to read, 0..2**ADDR_WIDTH, sampled with start
busy  output  1  high from the accepted start until done
done  output  1  1-cycle pulse after the last word is accepted, or for a zero-length command
ram_read_addr  output  ADDR_WIDTH  to RAM read_addr; registered
ram_q  input  DATA_WIDTH  from RAM q
m_data  output  DATA_WIDTH  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, m_valid=0, m_data=0, ram_read_addr=0; FIFO empty; all pipeline valid tags cleared.
- States:
  - IDLE: start=1 with length>0 -> RUN. Latch base_addr into the address register; remaining_issue=length; remaining_out=length.
  - IDLE: start=1 with length=0 -> DONE. No RAM reads, no stream beats.
  - RUN: issue reads until remaining_issue=0, then wait for outstanding words. The cycle the final word handshakes (m_valid&&m_ready with remaining_out=1) -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
  - start is ignored in RUN and DONE.
- Read pipeline:
  - Stage A: ram_read_addr register plus issue tag.
  - Stage B: RAM q valid the cycle after the RAM samples the address; tag delayed one cycle.
  - Tagged ram_q is written into the FIFO at the end of that cycle.
- Issue rule: a new address is loaded only when fifo_count + inflight(A,B) < FIFO_DEPTH, counting a same-cycle pop. Then address <= address+1, wrapping modulo 2**ADDR_WIDTH (base 2**ADDR_WIDTH-1 wraps to 0). When no issue, ram_read_addr holds and its tag is 0.
- Latency: start high in cycle 0 -> ram_read_addr=base in cycle 1 -> first m_valid in cycle 3 with m_data=RAM[base].
- Throughput: 1 word/cycle sustained while m_ready=1.
- Stream rules:
  - m_data/m_valid come from the FIFO head.
  - Once m_valid=1, m_data is stable until accepted.
  - The FIFO never overflows; an overflow would be a design error and must be asserted in simulation.
- Simultaneous FIFO push and pop in one cycle: count unchanged.
- busy=1 exactly in RUN.
- Data coherency: RAM read-during-write to the same address returns old data. Writers must not modify the window while busy.
- resetn asserted mid-transfer: immediate abort. Outputs take reset values, no done pulse, buffered data discarded.

Optional Feature:
- Macro: SDP_RAM_READER_LAST_EN.
- Defined: adds output m_last (1 bit, reset 0), carried per FIFO entry. High with the final word of each command only.
- Undefined: port absent, no extra storage, behaviour otherwise identical.

Test Plan:
- RAM preloaded RAM[i]=i; start, base=5, length=4, m_ready=1 -> beats 05,06,07,08 in cycles 3..6. done pulse in cycle 7, busy high cycles 1..6.
- base=62, length=4, ADDR_WIDTH=6 -> beats RAM[62],RAM[63],RAM[0],RAM[1]; wrap correct.
- length=64, m_ready toggling 1,0,0,1 repeating -> all 64 words in order, no loss or duplication; m_data stable while stalled; fifo_count never exceeds 4.
- length=0 -> done pulse next cycle; m_valid never asserted; ram_read_addr tag never set.
- start pulsed again during RUN with a different base -> ignored; original stream completes unchanged.
- resetn low for 1 cycle after 3 of 8 beats -> m_valid=0, busy=0 immediately, no done. A new start with base=0, length=2 then delivers RAM[0],RAM[1]. With SDP_RAM_READER_LAST_EN defined, m_last is high only on the second beat.
